// File: rtl/dino_jump.sv
// -----------------------------------------------------------------------------
// dino_jump
// Vertical-motion controller for the dino sprite. Turns the debounced up/down
// button levels into a 6-bit jump height above ground plus ducking/airborne
// status flags. Motion advances on a prescaled "step" tick; the collision
// stage can freeze all motion through the freeze input.
//
// Optional feature macro: DINO_FASTFALL_EN
//   defined   -> holding down while airborne forces a fall on the next step
//                and doubles the descent rate (2 px/step, saturating at 0).
//   undefined -> down is ignored while airborne; descent is 1 px/step.
//
// Parameters:
//   JUMP_MAX   apex height in pixels (1..63)
//   HANG_STEPS motion steps spent at apex before falling (0 = pass through)
//   STEP_DIV   clk cycles per motion step (>= 2)
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst       synchronous active-high reset, overrides every other input
//   up        jump button level (synchronous, debounced)
//   down      duck button level (synchronous, debounced)
//   freeze    game-over hold: state, height, hang and prescaler counters hold
//   y         registered height above ground
//   ducking   registered, high while ducking
//   airborne  registered, high while rising, hanging or falling
// -----------------------------------------------------------------------------
module dino_jump #(
    parameter int JUMP_MAX   = 48,
    parameter int HANG_STEPS = 6,
    parameter int STEP_DIV   = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       freeze,
    output logic [5:0] y,
    output logic       ducking,
    output logic       airborne
);

    localparam int DIV_W  = $clog2(STEP_DIV);
    localparam int HANG_W = (HANG_STEPS > 1) ? $clog2(HANG_STEPS + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST_C  = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE_C   = DIV_W'(1);
    localparam logic [HANG_W-1:0] HANG_LAST_C = HANG_W'(HANG_STEPS);
    localparam logic [HANG_W-1:0] HANG_ONE_C  = HANG_W'(1);
    localparam logic [5:0]        JUMP_MAX_C  = 6'(JUMP_MAX);

    typedef enum logic [2:0] {
        ST_GROUND = 3'd0,
        ST_DUCK   = 3'd1,
        ST_RISE   = 3'd2,
        ST_HANG   = 3'd3,
        ST_FALL   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [5:0]          y_r;
    logic [5:0]          y_nxt_s;
    logic [HANG_W-1:0]   hang_cnt_r;
    logic [HANG_W-1:0]   hang_nxt_s;
    logic [DIV_W-1:0]    div_cnt_r;
    logic [DIV_W-1:0]    div_nxt_s;
    logic                up_q_r;
    logic                ducking_r;
    logic                airborne_r;
    logic                ducking_nxt_s;
    logic                airborne_nxt_s;
    logic                step_s;
    logic                jump_req_s;
    logic                fast_s;
    logic [5:0]          fall_dec_s;

    // Step tick: one cycle per STEP_DIV clocks, at the last prescaler count.
    assign step_s     = (div_cnt_r == DIV_LAST_C);

    // Only a fresh press starts a jump; a held button never re-triggers.
    assign jump_req_s = up & ~up_q_r;

`ifdef DINO_FASTFALL_EN
    // Down held while airborne requests the fast-fall path.
    assign fast_s = down;
`else
    assign fast_s = 1'b0;
`endif

    // Fast fall removes two pixels per step, normal descent one.
    assign fall_dec_s = fast_s ? 6'd2 : 6'd1;

    // Prescaler next value: wrap at STEP_DIV-1.
    always_comb begin
        div_nxt_s = div_cnt_r;
        if (step_s) begin
            div_nxt_s = {DIV_W{1'b0}};
        end else begin
            div_nxt_s = div_cnt_r + DIV_ONE_C;
        end
    end

    // Next-state, next-height and hang-counter logic of the motion FSM.
    always_comb begin
        state_nxt_s = state_r;
        y_nxt_s     = y_r;
        hang_nxt_s  = hang_cnt_r;
        case (state_r)
            ST_GROUND: begin
                // Down wins over a simultaneous jump press; a jump press is
                // taken immediately without waiting for a step.
                y_nxt_s = 6'd0;
                if (down) begin
                    state_nxt_s = ST_DUCK;
                end else if (jump_req_s) begin
                    state_nxt_s = ST_RISE;
                end else begin
                    state_nxt_s = ST_GROUND;
                end
            end
            ST_DUCK: begin
                y_nxt_s = 6'd0;
                if (!down) begin
                    state_nxt_s = ST_GROUND;
                end else begin
                    state_nxt_s = ST_DUCK;
                end
            end
            ST_RISE: begin
                if (!step_s) begin
                    state_nxt_s = ST_RISE;
                end else if (fast_s) begin
                    state_nxt_s = ST_FALL;
                end else if (y_r >= (JUMP_MAX_C - 6'd1)) begin
                    // Reaching the apex: clamp to JUMP_MAX and start hanging.
                    y_nxt_s     = JUMP_MAX_C;
                    hang_nxt_s  = {HANG_W{1'b0}};
                    state_nxt_s = ST_HANG;
                end else begin
                    y_nxt_s     = y_r + 6'd1;
                    state_nxt_s = ST_RISE;
                end
            end
            ST_HANG: begin
                // HANG_STEPS counted steps, then the next step leaves for FALL,
                // so HANG_STEPS = 0 passes through on the first step.
                if (!step_s) begin
                    state_nxt_s = ST_HANG;
                end else if (fast_s) begin
                    state_nxt_s = ST_FALL;
                end else if (hang_cnt_r == HANG_LAST_C) begin
                    state_nxt_s = ST_FALL;
                end else begin
                    hang_nxt_s  = hang_cnt_r + HANG_ONE_C;
                    state_nxt_s = ST_HANG;
                end
            end
            ST_FALL: begin
                // Saturating descent; land when the result reaches zero.
                if (!step_s) begin
                    state_nxt_s = ST_FALL;
                end else if (y_r <= fall_dec_s) begin
                    y_nxt_s     = 6'd0;
                    state_nxt_s = ST_GROUND;
                end else begin
                    y_nxt_s     = y_r - fall_dec_s;
                    state_nxt_s = ST_FALL;
                end
            end
            default: begin
                state_nxt_s = ST_GROUND;
                y_nxt_s     = 6'd0;
                hang_nxt_s  = {HANG_W{1'b0}};
            end
        endcase
    end

    // Status flags decoded from the next state so they register alongside it.
    always_comb begin
        ducking_nxt_s  = 1'b0;
        airborne_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_GROUND: begin
                ducking_nxt_s  = 1'b0;
                airborne_nxt_s = 1'b0;
            end
            ST_DUCK: begin
                ducking_nxt_s  = 1'b1;
                airborne_nxt_s = 1'b0;
            end
            ST_RISE, ST_HANG, ST_FALL: begin
                ducking_nxt_s  = 1'b0;
                airborne_nxt_s = 1'b1;
            end
            default: begin
                ducking_nxt_s  = 1'b0;
                airborne_nxt_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers. The button history keeps sampling
    // during freeze so presses made while frozen are lost rather than queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_GROUND;
            y_r        <= 6'd0;
            hang_cnt_r <= {HANG_W{1'b0}};
            div_cnt_r  <= {DIV_W{1'b0}};
            up_q_r     <= 1'b0;
            ducking_r  <= 1'b0;
            airborne_r <= 1'b0;
        end else begin
            up_q_r <= up;
            if (!freeze) begin
                state_r    <= state_nxt_s;
                y_r        <= y_nxt_s;
                hang_cnt_r <= hang_nxt_s;
                div_cnt_r  <= div_nxt_s;
                ducking_r  <= ducking_nxt_s;
                airborne_r <= airborne_nxt_s;
            end
        end
    end

    assign y        = y_r;
    assign ducking  = ducking_r;
    assign airborne = airborne_r;

endmodule

// File: tb/tb_dino_jump.sv
// -----------------------------------------------------------------------------
// tb_dino_jump
// Self-checking bench for dino_jump with STEP_DIV=4, JUMP_MAX=8, HANG_STEPS=2.
// A table of per-cycle vectors covers ground/duck/freeze/reset behaviour; hand
// written sequences cover full jumps, held button, freeze mid-rise, reset
// mid-fall and (optionally) fast fall. Expected outputs are pushed to a
// scoreboard queue when inputs are driven and popped after the clock edge.
// -----------------------------------------------------------------------------
module tb_dino_jump;

    localparam int SD    = 4;
    localparam int JM    = 8;
    localparam int HS    = 2;
    localparam int TOTAL = 2 * JM + HS + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       up;
    logic       down;
    logic       freeze;
    logic [5:0] y;
    logic       ducking;
    logic       airborne;

    dino_jump #(
        .JUMP_MAX  (JM),
        .HANG_STEPS(HS),
        .STEP_DIV  (SD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .up      (up),
        .down    (down),
        .freeze  (freeze),
        .y       (y),
        .ducking (ducking),
        .airborne(airborne)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] y;
        logic       duck;
        logic       air;
    } obs_t;

    typedef struct {
        logic r;
        logic u;
        logic d;
        logic f;
        obs_t e;
    } vec_t;

    obs_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b1;

    // Reference: prescaler phase, mode (0 ground, 1 duck, 2 air) and the
    // number of steps taken since the jump started.
    int m_ph   = 0;
    int m_mode = 0;
    int m_k    = 0;
    bit m_upq  = 1'b0;

    // Height profile of an undisturbed jump after k steps.
    function automatic int prof(input int k);
        if (k <= JM) return k;
        else if (k <= JM + HS + 1) return JM;
        else return TOTAL - k;
    endfunction

    function automatic vec_t mk(input logic r, u, d, f, input int ey, input logic ed, ea);
        vec_t v;
        v.r = r; v.u = u; v.d = d; v.f = f;
        v.e.y = 6'(ey); v.e.duck = ed; v.e.air = ea;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, u, d, f, output obs_t e);
        bit jr;
        bit stp;
        if (r) begin
            m_ph = 0; m_upq = 1'b0; m_mode = 0; m_k = 0;
        end else begin
            jr    = u && !m_upq;
            m_upq = u;
            if (!f) begin
                stp  = (m_ph == SD - 1);
                m_ph = stp ? 0 : m_ph + 1;
                case (m_mode)
                    0: begin
                        if (d) m_mode = 1;
                        else if (jr) begin m_mode = 2; m_k = 0; end
                    end
                    1: if (!d) m_mode = 0;
                    default: begin
                        if (stp) begin
                            m_k++;
                            if (m_k >= TOTAL) m_mode = 0;
                        end
                    end
                endcase
            end
        end
        e.y    = (m_mode == 2) ? 6'(prof(m_k)) : 6'd0;
        e.duck = (m_mode == 1);
        e.air  = (m_mode == 2);
    endtask

    // One clock: drive, push expectation, wait for edge, pop and compare.
    task automatic drive(input logic r, u, d, f, input bit use_tbl, input obs_t te);
        obs_t me;
        obs_t ex;
        rst = r; up = u; down = d; freeze = f;
        model_step(r, u, d, f, me);
        if (use_tbl) sb_q.push_back(te);
        else if (chk_en) sb_q.push_back(me);
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            ex = sb_q.pop_front();
            check("y", int'(y), int'(ex.y));
            check("ducking", int'(ducking), int'(ex.duck));
            check("airborne", int'(airborne), int'(ex.air));
        end
    endtask

    task automatic cyc(input logic r, u, d, f);
        drive(r, u, d, f, 1'b0, '0);
    endtask

    task automatic run_until_y(input int target, input int bound, input string name);
        int n = 0;
        while (int'(y) != target && n < bound) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check(name, int'(y), target);
    endtask

    vec_t tbl[15];

    initial begin
        int first_c, land_c, max_y, n8, rises, n, vals[2], nchg, prev;
        bit prev_air, seen8;
        rst = 1'b1; up = 1'b0; down = 1'b0; freeze = 1'b0;

        //              rst   up    down  frz   y  duck  air
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);  // jump ignored in duck
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);  // back to ground
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);  // held up: no edge
        tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);  // down beats jump
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);  // edge during freeze
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);  // ... is discarded
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        tbl[13] = mk(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);  // reset overrides
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].r, tbl[i].u, tbl[i].d, tbl[i].f, 1'b1, tbl[i].e);
        end

        // Full jump from a one-cycle press.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("jump_airborne_next", int'(airborne), 1);
        check("jump_y_start", int'(y), 0);
        first_c = -1; land_c = -1; max_y = 0; n8 = 0;
        for (int c = 0; c < 200 && land_c < 0; c++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (int'(y) == 1 && first_c < 0) first_c = c;
            if (int'(y) == JM) n8++;
            if (int'(y) > max_y) max_y = int'(y);
            if (!airborne) land_c = c;
        end
        check("jump_apex", max_y, JM);
        check("jump_apex_cycles", n8, (HS + 2) * SD);
        check("jump_duration", land_c - first_c, (TOTAL - 1) * SD);

        // Holding up for 100 cycles gives exactly one jump.
        rises = 0; prev_air = 1'b0;
        for (int c = 0; c < 100; c++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            if (airborne && !prev_air) rises++;
            prev_air = airborne;
        end
        check("hold_one_jump", rises, 1);
        check("hold_landed", int'(airborne), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("repress_jumps", int'(airborne), 1);
        n = 0;
        while (airborne && n < 200) begin cyc(1'b0, 1'b0, 1'b0, 1'b0); n++; end
        check("repress_landed", int'(airborne), 0);

        // Freeze at y=5 while rising, with up toggling.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        run_until_y(5, 100, "frz_reach5");
        for (int i = 0; i < 40; i++) cyc(1'b0, (i % 2) == 1, 1'b0, 1'b1);
        check("frz_hold_y", int'(y), 5);
        n = 0;
        while (int'(y) == 5 && n < 8) begin cyc(1'b0, 1'b0, 1'b0, 1'b0); n++; end
        check("frz_resume_y", int'(y), 6);
        check("frz_resume_within_step", (n <= SD) ? 1 : 0, 1);
        n = 0;
        while (airborne && n < 200) begin cyc(1'b0, 1'b0, 1'b0, 1'b0); n++; end
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("frz_no_extra_jump", int'(airborne), 0);

        // Reset mid-fall at y=7.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        seen8 = 1'b0; n = 0;
        while (!(seen8 && int'(y) == 7) && n < 200) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (int'(y) == JM) seen8 = 1'b1;
            n++;
        end
        check("rstfall_at7", int'(y), 7);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("rstfall_y", int'(y), 0);
        check("rstfall_air", int'(airborne), 0);
        check("rstfall_duck", int'(ducking), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Down pressed at y=4 while rising.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        run_until_y(4, 100, "ff_reach4");
`ifdef DINO_FASTFALL_EN
        chk_en = 1'b0;
        prev = int'(y); nchg = 0; vals[0] = -1; vals[1] = -1; n = 0;
        while (airborne && n < 40) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            if (int'(y) != prev) begin
                if (nchg < 2) vals[nchg] = int'(y);
                nchg++;
            end
            prev = int'(y);
            n++;
        end
        check("ff_first_drop", vals[0], 2);
        check("ff_second_drop", vals[1], 0);
        check("ff_change_count", nchg, 2);
        check("ff_land_duck_low", int'(ducking), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("ff_duck_after_land", int'(ducking), 1);
        chk_en = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
`else
        n = 0;
        while (int'(y) != JM && n < 60) begin cyc(1'b0, 1'b0, 1'b1, 1'b0); n++; end
        check("noff_reaches_apex", int'(y), JM);
        check("noff_no_duck", int'(ducking), 0);
        n = 0;
        while (airborne && n < 200) begin cyc(1'b0, 1'b0, 1'b1, 1'b0); n++; end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("noff_duck_after_land", int'(ducking), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
`endif
        check("final_ground", int'(y), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on simulated time in case a loop misbehaves.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
